mem_data_responder: RTL and testbench
=====================================

# mem_data_responder

Data-memory responder that serves the processor's load/store port: it accepts one request at a time from the datapath over a valid/ready handshake, inserts a programmable number of wait states, and performs byte/half/word/doubleword accesses into an internal 64-bit-wide RAM. On loads it sign- or zero-extends the result, and it reports misaligned or out-of-range accesses. It sits between the processor datapath's address/data/write-enable outputs and the data RAM, and replaces the single-cycle combinational data path with a handshaked, multi-cycle one.

## Interface
- DEPTH, 256, number of 64-bit RAM entries; byte address space is DEPTH*8
- WAIT_STATES, 2, idle cycles inserted between acceptance and response (0..15)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  64  store data, LSB-aligned (bits [8*n-1:0] used)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  64  extended load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: req_ready=1. When req_valid is high, the request is accepted: all req_* fields are latched, the wait counter is loaded with WAIT_STATES, and the FSM goes to WAIT. If WAIT_STATES=0, it goes directly to RESP and commits on the same edge.
- WAIT: req_ready=0. The counter decrements each cycle. When the counter is 1, the next edge commits the access and moves to RESP.
- Commit (a single edge):
  - Compute the error check.
  - A store writes only the addressed byte lanes of entry addr[..:3].
  - A load extracts lanes starting at byte addr[2:0] and extends from bit 8n-1.
  - rsp_rdata and rsp_err are registered.
- RESP: rsp_valid=1, and the outputs are held stable until rsp_ready=1. On that edge the FSM goes to IDLE.
- Error: misaligned when addr mod (1<<req_size) != 0; out of range when addr >= DEPTH*8. On error, no RAM write occurs, rsp_rdata=0, and rsp_err=1.
- Only one request is in flight at a time. A new request is never accepted in the same cycle as a response handshake.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0. RAM contents are not cleared.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the acceptance edge.
- Throughput: one access per WAIT_STATES+2 cycles when rsp_ready is held at 1.
- A store is visible to a load accepted on any later cycle.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the access, and a pending store is not written.
  - Reset asserted in RESP drops the response, but an already-committed store remains in RAM.
- rsp_ready low in RESP: the FSM stalls indefinitely and all outputs are unchanged.
- req_valid high in WAIT/RESP is ignored. The requester must hold the request until req_ready is high.

## Configuration
- MEM_DATA_RESPONDER_ERR_EN defined:
  - Misalignment and range checks are active as described above.
- MEM_DATA_RESPONDER_ERR_EN undefined:
  - The checks are removed and rsp_err is tied to 0.
  - The address wraps modulo DEPTH*8.
  - Misaligned accesses are forced aligned by clearing the low req_size address bits before commit.

## Test plan
- Reset, then store doubleword 0x0123_4567_89AB_CDEF at addr 0x10, then load doubleword at 0x10 -> rsp_rdata=0x0123456789ABCDEF, rsp_err=0, rsp_valid 3 cycles after acceptance (WAIT_STATES=2).
- Store byte 0x80 at 0x13, then load byte signed at 0x13 -> 0xFFFF_FFFF_FFFF_FF80. Load byte unsigned at 0x13 -> 0x80. Load word at 0x10 -> bytes 0x10..0x12 unchanged from the prior test, byte 3 = 0x80.
- Load half at 0x11 with ERR_EN -> rsp_err=1, rsp_rdata=0. Store word at 0x0802 (DEPTH=256) -> rsp_err=1 and RAM unchanged. Without ERR_EN, load half at 0x11 returns the half at 0x10.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1 with data stable, req_ready stays 0, and the request presented meanwhile is not accepted until after the handshake.
- Assert reset in the middle of WAIT during a store of 0xDEAD at 0x20 -> outputs return to reset values immediately, and a later load at 0x20 returns the old contents.
- WAIT_STATES=0, back-to-back loads with rsp_ready=1 -> rsp_valid one cycle after each acceptance, and one access every 2 cycles.

Source files
------------

// File: rtl/mem_data_responder_if.sv
// Load/store port between the datapath and the data-memory responder.
// Valid/ready request channel plus valid/ready response channel.
interface mem_data_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size,
    output req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size,
    input  req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_data_responder.sv
// Handshaked data-memory responder with wait states and load extension.
// MEM_DATA_RESPONDER_ERR_EN enables misalign/range errors; else wrap+align.
module mem_data_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 reset,
  mem_data_responder_if.slave bus
);
  localparam int          AW    = $clog2(DEPTH * 8);
  localparam int          IW    = AW - 3;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we;
  logic        l_uns;
  logic [63:0] l_addr;
  logic [63:0] l_wdata;
  logic [1:0]  l_size;

  logic        c_we;
  logic        c_uns;
  logic [63:0] c_addr;
  logic [63:0] c_wdata;
  logic [1:0]  c_size;

  logic          accept;
  logic          commit;
  logic          err;
  logic [2:0]    amask;
  logic [7:0]    nbytes;
  logic [AW-1:0] a_eff;
  logic [IW-1:0] idx;
  logic [2:0]    off;
  logic [7:0]    be;
  logic [63:0]   wd_sh;
  logic [63:0]   rd_sh;
  logic [63:0]   rd_ext;
  logic [63:0]   rsp_next;
  logic          mem_we;

  logic [63:0] mem [DEPTH];

  assign accept = (state == IDLE) && bus.req_valid;
  assign commit = (accept && (WS == 4'd0)) ||
                  ((state == WAIT) && (cnt == 4'd1));

  // zero wait states commit straight from the live bus fields
  always_comb begin
    c_we    = l_we;
    c_uns   = l_uns;
    c_addr  = l_addr;
    c_wdata = l_wdata;
    c_size  = l_size;
    if (state == IDLE) begin
      c_we    = bus.req_we;
      c_uns   = bus.req_unsigned;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
      c_size  = bus.req_size;
    end
  end

  always_comb begin
    amask  = 3'd0;
    nbytes = 8'h01;
    unique case (c_size)
      2'd0: begin amask = 3'd0; nbytes = 8'h01; end
      2'd1: begin amask = 3'd1; nbytes = 8'h03; end
      2'd2: begin amask = 3'd3; nbytes = 8'h0f; end
      2'd3: begin amask = 3'd7; nbytes = 8'hff; end
    endcase
  end

`ifdef MEM_DATA_RESPONDER_ERR_EN
  assign a_eff = c_addr[AW-1:0];
  assign err   = ((c_addr[2:0] & amask) != 3'd0) ||
                 (c_addr >= 64'(DEPTH * 8));
`else
  logic unused_addr;
  assign unused_addr = ^c_addr[63:AW];
  assign a_eff = c_addr[AW-1:0] & ~{{(AW-3){1'b0}}, amask};
  assign err   = 1'b0;
`endif

  assign idx   = a_eff[AW-1:3];
  assign off   = a_eff[2:0];
  assign be    = nbytes << off;
  assign wd_sh = c_wdata << {off, 3'b000};
  assign rd_sh = mem[idx] >> {off, 3'b000};

  always_comb begin
    rd_ext = rd_sh;
    unique case (c_size)
      2'd0: rd_ext = c_uns ? {56'd0, rd_sh[7:0]}
                           : {{56{rd_sh[7]}}, rd_sh[7:0]};
      2'd1: rd_ext = c_uns ? {48'd0, rd_sh[15:0]}
                           : {{48{rd_sh[15]}}, rd_sh[15:0]};
      2'd2: rd_ext = c_uns ? {32'd0, rd_sh[31:0]}
                           : {{32{rd_sh[31]}}, rd_sh[31:0]};
      2'd3: rd_ext = rd_sh;
    endcase
  end

  assign rsp_next = (c_we || err) ? 64'd0 : rd_ext;
  assign mem_we   = commit && c_we && !err && !reset;

  // RAM is never cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      l_we          <= 1'b0;
      l_uns         <= 1'b0;
      l_addr        <= 64'd0;
      l_wdata       <= 64'd0;
      l_size        <= 2'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 64'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            l_we          <= bus.req_we;
            l_uns         <= bus.req_unsigned;
            l_addr        <= bus.req_addr;
            l_wdata       <= bus.req_wdata;
            l_size        <= bus.req_size;
            cnt           <= WS;
            bus.req_ready <= 1'b0;
            state         <= (WS == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= rsp_next;
        bus.rsp_err   <= err;
      end
    end
  end
endmodule

// File: tb/tb_mem_data_responder.sv
// Directed bench for mem_data_responder: 2-wait-state and 0-wait-state
// instances, load/store/extension/error/stall/reset scenarios.
module tb_mem_data_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_data_responder_if b ();
  mem_data_responder_if b0 ();

  mem_data_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .bus(b.slave)
  );
  mem_data_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );

  always #5 clk = ~clk;

  logic [63:0] rd;
  logic        er;
  int          lat;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [63:0] a,
                      input logic [1:0] sz, input logic uns,
                      input logic [63:0] wd,
                      output logic [63:0] r, output logic e,
                      output int l);
    int n;
    @(negedge clk);
    b.req_valid    = 1'b1;
    b.req_we       = we;
    b.req_addr     = a;
    b.req_size     = sz;
    b.req_unsigned = uns;
    b.req_wdata    = wd;
    n = 0;
    while (!b.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b.req_valid = 1'b0;
    l = 1;
    while (!b.rsp_valid && l < 50) begin
      @(negedge clk);
      l++;
    end
    r = b.rsp_rdata;
    e = b.rsp_err;
    b.rsp_ready = 1'b1;
    @(negedge clk);
    b.rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b.req_valid = 0; b.req_we = 0; b.req_addr = 0; b.req_size = 0;
    b.req_unsigned = 0; b.req_wdata = 0; b.rsp_ready = 0;
    b0.req_valid = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_size = 0;
    b0.req_unsigned = 0; b0.req_wdata = 0; b0.rsp_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", b.req_ready, 1);
    check("rst_valid", b.rsp_valid, 0);
    check("rst_rdata", b.rsp_rdata, 0);
    check("rst_err", b.rsp_err, 0);
    reset = 1'b0;

    xact(1, 64'h10, 3, 0, 64'h0123_4567_89AB_CDEF, rd, er, lat);
    check("sd_rdata", rd, 0);
    check("sd_err", er, 0);
    check("sd_lat", lat, 3);
    xact(0, 64'h10, 3, 0, 0, rd, er, lat);
    check("ld_rdata", rd, 64'h0123_4567_89AB_CDEF);
    check("ld_err", er, 0);
    check("ld_lat", lat, 3);

    xact(1, 64'h13, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, rd, er, lat);
    check("sb_err", er, 0);
    xact(0, 64'h10, 3, 0, 0, rd, er, lat);
    check("ld_after_sb", rd, 64'h0123_4567_80AB_CDEF);
    xact(0, 64'h13, 0, 0, 0, rd, er, lat);
    check("lb", rd, 64'hFFFF_FFFF_FFFF_FF80);
    xact(0, 64'h13, 0, 1, 0, rd, er, lat);
    check("lbu", rd, 64'h80);
    xact(0, 64'h10, 2, 0, 0, rd, er, lat);
    check("lw", rd, 64'hFFFF_FFFF_80AB_CDEF);
    xact(0, 64'h14, 1, 1, 0, rd, er, lat);
    check("lhu", rd, 64'h4567);

    xact(0, 64'h11, 1, 1, 0, rd, er, lat);
`ifdef MEM_DATA_RESPONDER_ERR_EN
    check("mis_err", er, 1);
    check("mis_rdata", rd, 0);
`else
    check("mis_err", er, 0);
    check("mis_rdata", rd, 64'hCDEF);
`endif

    xact(1, 64'h0, 3, 0, 64'hA5A5_A5A5_5A5A_5A5A, rd, er, lat);
    xact(1, 64'h802, 2, 0, 64'hFFFF_FFFF_1122_3344, rd, er, lat);
    xact(0, 64'h0, 3, 0, 0, rd, er, lat);
`ifdef MEM_DATA_RESPONDER_ERR_EN
    check("oor_ram", rd, 64'hA5A5_A5A5_5A5A_5A5A);
`else
    check("wrap_ram", rd, 64'hA5A5_A5A5_1122_3344);
`endif

    // stall in RESP with a second request already presented
    @(negedge clk);
    b.req_valid = 1; b.req_we = 0; b.req_addr = 64'h10;
    b.req_size = 3; b.req_unsigned = 0;
    @(negedge clk);
    b.req_addr = 64'h13; b.req_size = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", b.rsp_valid, 1);
      check("stall_rdata", b.rsp_rdata, 64'h0123_4567_80AB_CDEF);
      check("stall_ready", b.req_ready, 0);
      @(negedge clk);
    end
    b.rsp_ready = 1;
    @(negedge clk);
    b.rsp_ready = 0;
    check("hs_valid", b.rsp_valid, 0);
    check("hs_ready", b.req_ready, 1);
    @(negedge clk);
    check("acc2_ready", b.req_ready, 0);
    b.req_valid = 0;
    repeat (2) @(negedge clk);
    check("acc2_valid", b.rsp_valid, 1);
    check("acc2_rdata", b.rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    b.rsp_ready = 1;
    @(negedge clk);
    b.rsp_ready = 0;

    // reset during WAIT aborts a pending store
    xact(1, 64'h20, 3, 0, 64'h1111_2222_3333_4444, rd, er, lat);
    @(negedge clk);
    b.req_valid = 1; b.req_we = 1; b.req_addr = 64'h20;
    b.req_size = 1; b.req_wdata = 64'hDEAD;
    @(negedge clk);
    b.req_valid = 0;
    check("wait_busy", b.req_ready, 0);
    #2 reset = 1;
    #1;
    check("rw_ready", b.req_ready, 1);
    check("rw_valid", b.rsp_valid, 0);
    check("rw_rdata", b.rsp_rdata, 0);
    check("rw_err", b.rsp_err, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    xact(0, 64'h20, 3, 0, 0, rd, er, lat);
    check("abort_ram", rd, 64'h1111_2222_3333_4444);

    // reset during RESP keeps the committed store
    @(negedge clk);
    b.req_valid = 1; b.req_we = 1; b.req_addr = 64'h28;
    b.req_size = 3; b.req_wdata = 64'hCAFE;
    @(negedge clk);
    b.req_valid = 0;
    repeat (2) @(negedge clk);
    check("rr_valid", b.rsp_valid, 1);
    reset = 1;
    @(negedge clk);
    check("rr_drop", b.rsp_valid, 0);
    reset = 0;
    xact(0, 64'h28, 3, 0, 0, rd, er, lat);
    check("rr_ram", rd, 64'hCAFE);

    // zero wait states, request and rsp_ready held high
    @(negedge clk);
    b0.rsp_ready = 1;
    b0.req_valid = 1; b0.req_we = 1; b0.req_addr = 64'h8;
    b0.req_size = 3; b0.req_wdata = 64'h8877_6655_4433_2211;
    @(negedge clk);
    check("z_st_valid", b0.rsp_valid, 1);
    check("z_st_ready", b0.req_ready, 0);
    b0.req_we = 0;
    @(negedge clk);
    check("z_hs_valid", b0.rsp_valid, 0);
    check("z_hs_ready", b0.req_ready, 1);
    @(negedge clk);
    check("z_ld_valid", b0.rsp_valid, 1);
    check("z_ld_rdata", b0.rsp_rdata, 64'h8877_6655_4433_2211);
    b0.req_addr = 64'hF; b0.req_size = 0; b0.req_unsigned = 0;
    @(negedge clk);
    check("z_hs2_ready", b0.req_ready, 1);
    @(negedge clk);
    b0.req_valid = 0;
    check("z_lb_valid", b0.rsp_valid, 1);
    check("z_lb_rdata", b0.rsp_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    @(negedge clk);
    b0.rsp_ready = 0;
    check("z_end_valid", b0.rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
